// File: rtl/muldiv_ctrl_if.sv
// E-stage request / HI-LO result bundle for the multiply/divide sequencer.
// abort exists only when MULDIV_ABORT_EN is defined.
interface muldiv_ctrl_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        md_use_d;
`ifdef MULDIV_ABORT_EN
  logic        abort;
`endif
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, rs_data, rt_data, md_use_d,
`ifdef MULDIV_ABORT_EN
    output abort,
`endif
    input  busy, stall_req, hi, lo
  );

  modport slave (
    input  start, md_op, rs_data, rt_data, md_use_d,
`ifdef MULDIV_ABORT_EN
    input  abort,
`endif
    output busy, stall_req, hi, lo
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Fixed-latency MIPS multiply/divide sequencer owning HI/LO.
// Optional macro MULDIV_ABORT_EN adds a flush input that cancels an in-flight op.
module muldiv_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_ctrl_if.slave md
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        pend_wr_q, pend_wr_d;
  logic        abort_w;

`ifdef MULDIV_ABORT_EN
  assign abort_w = md.abort;
`else
  assign abort_w = 1'b0;
`endif

  logic [31:0] rs, rt;
  logic [63:0] prod_s, prod_u;
  logic        rt_nz;
  logic [31:0] a_abs, b_abs, b_safe, uq, ur, sq, sr, rt_safe, dq, dr;

  assign rs = md.rs_data;
  assign rt = md.rt_data;

  // Low 64 bits of a product of sign-extended operands equal the signed product.
  assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
  assign prod_u = {32'd0, rs} * {32'd0, rt};

  assign rt_nz   = (rt != '0);
  assign a_abs   = rs[31] ? -rs : rs;
  assign b_abs   = rt[31] ? -rt : rt;
  assign b_safe  = rt_nz ? b_abs : 32'd1;
  assign uq      = a_abs / b_safe;
  assign ur      = a_abs % b_safe;
  assign sq      = (rs[31] ^ rt[31]) ? -uq : uq;
  assign sr      = rs[31] ? -ur : ur;
  assign rt_safe = rt_nz ? rt : 32'd1;
  assign dq      = rs / rt_safe;
  assign dr      = rs % rt_safe;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      IDLE: begin
        if (md.start && !abort_w) begin
          case (md.md_op)
            OP_MULT: begin
              {pend_hi_d, pend_lo_d} = prod_s;
              pend_wr_d = 1'b1;
              cnt_d     = 4'(MULT_CYCLES);
              state_d   = RUN;
            end
            OP_MULTU: begin
              {pend_hi_d, pend_lo_d} = prod_u;
              pend_wr_d = 1'b1;
              cnt_d     = 4'(MULT_CYCLES);
              state_d   = RUN;
            end
            OP_DIV: begin
              pend_hi_d = sr;
              pend_lo_d = sq;
              pend_wr_d = rt_nz;
              cnt_d     = 4'(DIV_CYCLES);
              state_d   = RUN;
            end
            OP_DIVU: begin
              pend_hi_d = dr;
              pend_lo_d = dq;
              pend_wr_d = rt_nz;
              cnt_d     = 4'(DIV_CYCLES);
              state_d   = RUN;
            end
            OP_MTHI: hi_d = rs;
            OP_MTLO: lo_d = rs;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (abort_w) begin
          state_d   = IDLE;
          cnt_d     = '0;
          pend_wr_d = 1'b0;
        end else if (cnt_q <= 4'd1) begin
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          state_d   = IDLE;
          cnt_d     = '0;
          pend_wr_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign md.busy      = (state_q == RUN);
  assign md.stall_req = md.md_use_d &
                        (md.busy | (md.start & (md.md_op >= OP_MULT) & (md.md_op <= OP_DIVU)));
  assign md.hi        = hi_q;
  assign md.lo        = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl (MULT_CYCLES=5, DIV_CYCLES=10).
module tb_muldiv_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   n;
  int   stalls;

  always #5 clk = ~clk;

  muldiv_ctrl_if md_if ();

  muldiv_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk  (clk),
    .reset(reset),
    .md   (md_if.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Leaves the caller at the falling edge just after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    md_if.start   = 1'b1;
    md_if.md_op   = op;
    md_if.rs_data = a;
    md_if.rt_data = b;
    @(negedge clk);
    md_if.start = 1'b0;
    md_if.md_op = 3'd0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (md_if.busy === 1'b1 && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    md_if.start    = 1'b0;
    md_if.md_op    = 3'd0;
    md_if.rs_data  = '0;
    md_if.rt_data  = '0;
    md_if.md_use_d = 1'b0;
`ifdef MULDIV_ABORT_EN
    md_if.abort    = 1'b0;
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_hi", md_if.hi, 32'h0);
    chk("rst_lo", md_if.lo, 32'h0);
    chk("rst_busy", 32'(md_if.busy), 32'd0);
    chk("rst_stall", 32'(md_if.stall_req), 32'd0);

    issue(3'd1, 32'hFFFF_FFFE, 32'h0000_0003);
    wait_idle(n);
    chk("mult_busy", n, 5);
    chk("mult_hi", md_if.hi, 32'hFFFF_FFFF);
    chk("mult_lo", md_if.lo, 32'hFFFF_FFFA);

    issue(3'd2, 32'hFFFF_FFFE, 32'h0000_0003);
    wait_idle(n);
    chk("multu_busy", n, 5);
    chk("multu_hi", md_if.hi, 32'h0000_0002);
    chk("multu_lo", md_if.lo, 32'hFFFF_FFFA);

    issue(3'd3, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_idle(n);
    chk("div_busy", n, 10);
    chk("div_lo", md_if.lo, 32'hFFFF_FFFD);
    chk("div_hi", md_if.hi, 32'hFFFF_FFFF);

    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    chk("divmin_busy", n, 10);
    chk("divmin_lo", md_if.lo, 32'h8000_0000);
    chk("divmin_hi", md_if.hi, 32'h0);

    issue(3'd7, 32'h1234_5678, 32'h9ABC_DEF0);
    chk("rsv_busy", 32'(md_if.busy), 32'd0);
    chk("rsv_lo", md_if.lo, 32'h8000_0000);
    chk("rsv_hi", md_if.hi, 32'h0);

    issue(3'd5, 32'h0000_0011, 32'h0);
    chk("mthi_hi", md_if.hi, 32'h0000_0011);
    chk("mthi_busy", 32'(md_if.busy), 32'd0);
    issue(3'd6, 32'h0000_0022, 32'h0);
    chk("mtlo_lo", md_if.lo, 32'h0000_0022);

    issue(3'd4, 32'h0000_0007, 32'h0);
    wait_idle(n);
    chk("divu0_busy", n, 10);
    chk("divu0_hi", md_if.hi, 32'h0000_0011);
    chk("divu0_lo", md_if.lo, 32'h0000_0022);

    // DIV 100/7 with md_use_d held high and a MULT injected mid-operation.
    md_if.md_use_d = 1'b1;
    @(negedge clk);
    md_if.start   = 1'b1;
    md_if.md_op   = 3'd3;
    md_if.rs_data = 32'd100;
    md_if.rt_data = 32'd7;
    #1 chk("stall_start", 32'(md_if.stall_req), 32'd1);
    @(negedge clk);
    md_if.start = 1'b0;
    n      = 0;
    stalls = 0;
    while (md_if.busy === 1'b1 && n < 40) begin
      if (n == 2) begin
        md_if.start   = 1'b1;
        md_if.md_op   = 3'd1;
        md_if.rs_data = 32'd3;
        md_if.rt_data = 32'd4;
      end else begin
        md_if.start = 1'b0;
        md_if.md_op = 3'd0;
      end
      if (md_if.stall_req === 1'b1) stalls++;
      n++;
      @(negedge clk);
    end
    md_if.start = 1'b0;
    md_if.md_op = 3'd0;
    chk("stall_busy", n, 10);
    chk("stall_cycles", stalls, 10);
    chk("stall_after", 32'(md_if.stall_req), 32'd0);
    chk("ign_hi", md_if.hi, 32'd2);
    chk("ign_lo", md_if.lo, 32'd14);
    md_if.md_use_d = 1'b0;

`ifdef MULDIV_ABORT_EN
    issue(3'd5, 32'h5, 32'h0);
    issue(3'd6, 32'h6, 32'h0);
    issue(3'd3, 32'd100, 32'd7);
    repeat (2) @(negedge clk);
    md_if.abort = 1'b1;
    @(negedge clk);
    md_if.abort = 1'b0;
    chk("abort_busy", 32'(md_if.busy), 32'd0);
    chk("abort_hi", md_if.hi, 32'h5);
    chk("abort_lo", md_if.lo, 32'h6);
    repeat (12) @(negedge clk);
    chk("abort_late_lo", md_if.lo, 32'h6);
    md_if.start   = 1'b1;
    md_if.md_op   = 3'd6;
    md_if.rs_data = 32'h99;
    md_if.abort   = 1'b1;
    @(negedge clk);
    md_if.start = 1'b0;
    md_if.md_op = 3'd0;
    md_if.abort = 1'b0;
    chk("abort_mtlo", md_if.lo, 32'h6);
`endif

    // Asynchronous reset between edges during cycle 3 of a MULT.
    issue(3'd1, 32'd3, 32'd4);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 32'(md_if.busy), 32'd0);
    chk("arst_hi", md_if.hi, 32'h0);
    chk("arst_lo", md_if.lo, 32'h0);
    #1 reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("arst_late_busy", 32'(md_if.busy), 32'd0);
    chk("arst_late_lo", md_if.lo, 32'h0);
    chk("arst_late_hi", md_if.hi, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Multi-cycle multiply/divide sequencer for the 5-stage MIPS pipeline.
- Owns the HI/LO registers and accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage.
- Models fixed operation latency with a busy counter and raises a stall request to the hazard logic when a D-stage instruction needs the unit while it is occupied.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  E-stage md instruction valid this cycle; qualifies md_op.
- md_op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
- rs_data  input  32  forwarded rs operand (dividend / multiplicand / MT source).
- rt_data  input  32  forwarded rt operand (divisor / multiplier).
- md_use_d  input  1  D-stage instruction is any md op or MFHI/MFLO.
- busy  output  1  operation in progress.
- stall_req  output  1  combinational: md_use_d & (busy | (start & md_op in 1..4)).
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (async, any time, including mid-operation):
  - busy=0, cnt=0, hi=0, lo=0, pending results cleared.
  - Any in-flight operation is discarded.
- States:
  - IDLE (busy=0) and RUN (busy=1).
  - cnt is 4 bits.
- IDLE, start with op 1..4 sampled at edge E0:
  - Result is computed from rs_data/rt_data at E0 and held in pend_hi/pend_lo.
  - cnt loads N (MULT_CYCLES or DIV_CYCLES); go to RUN.
- RUN, each edge:
  - If cnt>1: cnt decrements.
  - If cnt==1: hi/lo take pend_hi/pend_lo, cnt=0, go to IDLE.
  - busy is high for exactly N cycles after E0; new hi/lo are visible in the first cycle busy is low.
- IDLE, start with MTHI/MTLO:
  - hi (or lo) takes rs_data at that edge.
  - No busy, no latency.
- start while busy (any op): ignored. The hazard unit prevents this; the unit must not corrupt state.
- NONE or reserved op with start=1: no effect.
- Arithmetic:
  - MULT: signed 32x32 -> 64; hi = upper, lo = lower.
  - MULTU: unsigned 32x32 -> 64; hi = upper, lo = lower.
  - DIV (signed): lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
    - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - DIVU: unsigned quotient/remainder.
  - Divisor 0 (DIV/DIVU): full DIV_CYCLES busy period; hi/lo unchanged at commit.
- Outputs hi/lo are registered. No read-port latency; mfhi/mflo read hi/lo directly.
- stall_req is combinational and has no reset dependency beyond busy.

Optional Feature:
- Macro MULDIV_ABORT_EN.
- When defined:
  - Adds input port abort (1 bit), asserted by the exception/flush logic.
  - abort high at an edge forces IDLE, cnt=0 and discards the pending result; hi/lo are unchanged.
  - A start in the same cycle as abort is ignored, including MTHI/MTLO.
  - abort while IDLE has no effect.
- When undefined:
  - No abort port.
  - Every accepted operation runs to completion; only reset cancels.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, release -> hi=0, lo=0, busy=0, stall_req=0.
- MULT rs=0xFFFFFFFE (-2), rt=0x00000003, start 1 cycle:
  - Response: busy high exactly 5 cycles.
  - Response: then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - Response: MULTU on the same operands gives hi=0x00000002, lo=0xFFFFFFFA.
- DIV rs=0xFFFFFFF9 (-7), rt=0x00000002:
  - Response: busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Response: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - Response: DIVU 7/0 after MTHI 0x11 / MTLO 0x22 leaves hi=0x11, lo=0x22.
- Stall and ignore:
  - Stimulus: md_use_d=1 in the start cycle of DIV and throughout.
  - Response: stall_req=1 from the start cycle through the last busy cycle, 0 after.
  - Stimulus: start MULT mid-DIV.
  - Response: ignored; the DIV result commits unchanged at the original cycle.
- Reset mid-operation:
  - Stimulus: async reset pulse between clock edges at cycle 3 of MULT.
  - Response: busy=0 and hi/lo=0 immediately; no later commit occurs.
- MULDIV_ABORT_EN:
  - Stimulus: abort at cycle 4 of DIV 100/7 with prior hi=0x5, lo=0x6.
  - Response: busy=0 next cycle; hi=0x5, lo=0x6 retained.
  - Stimulus: MTLO with abort in the same cycle.
  - Response: lo unchanged.
